// File: rtl/mdio_responder_if.sv
// Pin-level and register-event signals of the MDIO responder, grouped as one bundle.
// The slave modport is the responder side; the master modport is the MAC/bench side.
interface mdio_responder_if;
  logic        mdc_i;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oen_o;
  logic [15:0] status_i;
  logic        wr_valid_o;
  logic [4:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        rd_valid_o;

  modport slave (
    input  mdc_i, mdio_i, status_i,
    output mdio_o, mdio_oen_o, wr_valid_o, wr_addr_o, wr_data_o, rd_valid_o
  );

  modport master (
    output mdc_i, mdio_i, status_i,
    input  mdio_o, mdio_oen_o, wr_valid_o, wr_addr_o, wr_data_o, rd_valid_o
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO on clk_i, decodes frames for PhyAddr
// and serves a 32x16 register file (reg1 live status, reg2/3 PHY ID, reg0 soft reset).
//
// state      | meaning
// PREAMBLE   | counting consecutive 1s, waiting for the 0 of the start field
// START      | expecting the 1 of the start field
// OP         | shifting in the 2-bit opcode
// PHYAD      | shifting in the 5-bit PHY address
// REGAD      | shifting in the 5-bit register address, then accept or reject
// TA         | turnaround; a read drives 0 here, a write ignores two bits
// DATA       | reads drive 16 bits then release; writes shift in 16 bits
// SKIP       | frame not for us: consume TA + data without driving
module mdio_responder #(
  parameter logic [4:0]  PhyAddr     = 5'd1,
  parameter int unsigned SyncDepth   = 2,
  parameter int unsigned PreambleLen = 32,
  parameter int unsigned IdleTimeout = 1024,
  parameter logic [15:0] Reg0Reset   = 16'h1140,
  parameter logic [15:0] PhyId1      = 16'h0141,
  parameter logic [15:0] PhyId2      = 16'h0CC2
) (
  input logic             clk_i,
  input logic             rst_ni,
  mdio_responder_if.slave bus
);

  localparam int unsigned PW = $clog2(PreambleLen + 1);
  localparam int unsigned IW = $clog2(IdleTimeout + 1);
  localparam logic [PW-1:0] PreMax  = PW'(PreambleLen);
  localparam logic [IW-1:0] IdleMax = IW'(IdleTimeout);

  typedef enum logic [2:0] {
    S_PREAMBLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
  } state_e;

  logic [SyncDepth-1:0] mdc_sync_q, mdio_sync_q;
  logic                 mdc_prev_q;
  logic                 mdc_s, bit_s, rise;
  logic [IW-1:0]        idle_cnt_q;
  logic                 idle_to;

  state_e        state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]    op_q, op_d;
  logic [4:0]    phy_q, phy_d;
  logic [4:0]    regad_q, regad_d;
  logic [15:0]   shift_q, shift_d;
  logic          is_rd_q, is_rd_d;
  logic          oen_q, oen_d;
  logic          mdo_q, mdo_d;
  logic          rd_pulse, wr_commit, writable;
  logic [4:0]    regad_full;
  logic [15:0]   wdata_full, rd_value;
  logic          wr_valid_q, rd_valid_q;
  logic [4:0]    wr_addr_q;
  logic [15:0]   wr_data_q;
  logic [15:0]   regs_q [32];

  assign mdc_s = mdc_sync_q[SyncDepth-1];
  assign bit_s = mdio_sync_q[SyncDepth-1];
  assign rise  = mdc_s & ~mdc_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SyncDepth-2:0], bus.mdc_i};
      mdio_sync_q <= {mdio_sync_q[SyncDepth-2:0], bus.mdio_i};
      mdc_prev_q  <= mdc_s;
      if (rise) idle_cnt_q <= '0;
      else if (idle_cnt_q != IdleMax) idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign idle_to = (idle_cnt_q == IdleMax);

  assign regad_full = {regad_q[3:0], bit_s};
  assign wdata_full = {shift_q[14:0], bit_s};
  assign writable   = (regad_q != 5'd1) && (regad_q != 5'd2) && (regad_q != 5'd3);

  always_comb begin
    case (regad_full)
      5'd1:    rd_value = bus.status_i;
      5'd2:    rd_value = PhyId1;
      5'd3:    rd_value = PhyId2;
      default: rd_value = regs_q[regad_full];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_PREAMBLE;
      bit_cnt_q <= '0;
      pre_cnt_q <= '0;
      op_q      <= '0;
      phy_q     <= '0;
      regad_q   <= '0;
      shift_q   <= '0;
      is_rd_q   <= 1'b0;
      oen_q     <= 1'b1;
      mdo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      op_q      <= op_d;
      phy_q     <= phy_d;
      regad_q   <= regad_d;
      shift_q   <= shift_d;
      is_rd_q   <= is_rd_d;
      oen_q     <= oen_d;
      mdo_q     <= mdo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pre_cnt_d = pre_cnt_q;
    op_d      = op_q;
    phy_d     = phy_q;
    regad_d   = regad_q;
    shift_d   = shift_q;
    is_rd_d   = is_rd_q;
    oen_d     = oen_q;
    mdo_d     = mdo_q;
    rd_pulse  = 1'b0;
    wr_commit = 1'b0;
    if (rise) begin
      case (state_q)
        S_PREAMBLE: begin
          // Counter saturates at PreMax, so equality covers "at least PreambleLen".
          if (bit_s) begin
            if (pre_cnt_q != PreMax) pre_cnt_d = pre_cnt_q + 1'b1;
          end else if (pre_cnt_q == PreMax) begin
            state_d   = S_START;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
        S_START: begin
          bit_cnt_d = '0;
          state_d   = bit_s ? S_OP : S_PREAMBLE;
        end
        S_OP: begin
          op_d = {op_q[0], bit_s};
          if (bit_cnt_q == 5'd1) begin
            state_d   = S_PHYAD;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_PHYAD: begin
          phy_d = {phy_q[3:0], bit_s};
          if (bit_cnt_q == 5'd4) begin
            state_d   = S_REGAD;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_REGAD: begin
          regad_d = regad_full;
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = '0;
            if (((op_q == 2'b10) || (op_q == 2'b01)) && (phy_q == PhyAddr)) begin
              state_d = S_TA;
              is_rd_d = (op_q == 2'b10);
              if (op_q == 2'b10) begin
                shift_d  = rd_value;
                rd_pulse = 1'b1;
              end
            end else begin
              state_d = S_SKIP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_TA: begin
          if (is_rd_q) begin
            oen_d     = 1'b0;
            mdo_d     = 1'b0;
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else if (bit_cnt_q == 5'd1) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_DATA: begin
          if (is_rd_q) begin
            if (bit_cnt_q == 5'd16) begin
              oen_d   = 1'b1;
              mdo_d   = 1'b0;
              state_d = S_PREAMBLE;
            end else begin
              mdo_d     = shift_q[15];
              shift_d   = {shift_q[14:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            shift_d = wdata_full;
            if (bit_cnt_q == 5'd15) begin
              wr_commit = 1'b1;
              state_d   = S_PREAMBLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        S_SKIP: begin
          if (bit_cnt_q == 5'd17) state_d = S_PREAMBLE;
          else bit_cnt_d = bit_cnt_q + 5'd1;
        end
        default: state_d = S_PREAMBLE;
      endcase
    end else if (idle_to && (state_q != S_PREAMBLE)) begin
      state_d   = S_PREAMBLE;
      pre_cnt_d = '0;
      oen_d     = 1'b1;
      mdo_d     = 1'b0;
    end
  end

  // Soft reset via reg0[15] clears storage; reg0 comes back with bit 15 low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      regs_q[0] <= Reg0Reset;
    end else if (wr_commit && writable) begin
      if ((regad_q == 5'd0) && wdata_full[15]) begin
        for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        regs_q[0] <= Reg0Reset & 16'h7FFF;
      end else begin
        regs_q[regad_q] <= wdata_full;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= wr_commit && writable;
      rd_valid_q <= rd_pulse;
      if (wr_commit && writable) begin
        wr_addr_q <= regad_q;
        wr_data_q <= wdata_full;
      end
    end
  end

  assign bus.mdio_o     = mdo_q;
  assign bus.mdio_oen_o = oen_q;
  assign bus.wr_valid_o = wr_valid_q;
  assign bus.wr_addr_o  = wr_addr_q;
  assign bus.wr_data_o  = wr_data_q;
  assign bus.rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a bit-level MDIO master drives frames, and a register-map
// model computes the expected bus data and register-event pulses.
module tb_mdio_responder;
  localparam int Half = 5;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic mst_drv = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wr_hi = 0;
  int   rd_hi = 0;
  int   drv_cyc = 0;
  logic [4:0]  last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic [15:0] mregs [32];

  always #5 clk_i = ~clk_i;

  mdio_responder_if bus();

  // Open-drain style bus with pull-up: DUT wins when it drives, else the master value.
  assign bus.mdio_i = bus.mdio_oen_o ? mst_drv : bus.mdio_o;

  mdio_responder dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always @(negedge clk_i) begin
    if (bus.wr_valid_o) begin
      wr_hi <= wr_hi + 1;
      last_wr_addr <= bus.wr_addr_o;
      last_wr_data <= bus.wr_data_o;
    end
    if (bus.rd_valid_o) rd_hi <= rd_hi + 1;
    if (!bus.mdio_oen_o) drv_cyc <= drv_cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 16'h0000;
    mregs[0] = 16'h1140;
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] a, input logic [15:0] st);
    case (a)
      5'd1:    return st;
      5'd2:    return 16'h0141;
      5'd3:    return 16'h0CC2;
      default: return mregs[a];
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    if (a >= 5'd1 && a <= 5'd3) return;
    if (a == 5'd0 && d[15]) begin
      model_reset();
      mregs[0] = 16'h1140 & 16'h7FFF;
    end else begin
      mregs[a] = d;
    end
  endtask

  // One MDC period: drive while low, sample the line just before the rising edge.
  task automatic mdc_bit(input logic b, input logic rel, output logic smp);
    mst_drv = rel ? 1'b1 : b;
    repeat (Half) @(posedge clk_i);
    #1;
    smp = bus.mdio_i;
    bus.mdc_i = 1'b1;
    repeat (Half) @(posedge clk_i);
    #1;
    bus.mdc_i = 1'b0;
  endtask

  task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [15:0] wd, input logic rel,
                            input int n_tail, output logic [16:0] rsp);
    logic s;
    logic b;
    rsp = '0;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b0, s);
    mdc_bit(1'b0, 1'b0, s);
    mdc_bit(1'b1, 1'b0, s);
    mdc_bit(op[1], 1'b0, s);
    mdc_bit(op[0], 1'b0, s);
    for (int i = 4; i >= 0; i--) mdc_bit(phy[i], 1'b0, s);
    for (int i = 4; i >= 0; i--) mdc_bit(ra[i], 1'b0, s);
    for (int k = 0; k < n_tail; k++) begin
      if (k == 0) b = 1'b1;
      else if (k == 1) b = 1'b0;
      else b = wd[17-k];
      mdc_bit(b, rel, s);
      if (k >= 1) rsp = {rsp[15:0], s};
    end
  endtask

  task automatic do_txn(input int pre, input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] ra, input logic [15:0] wd, input logic [15:0] st,
                        input string tag);
    int wr0, rd0, dr0;
    logic [16:0] rsp;
    logic accepted, wrable;
    logic [15:0] exp;
    wr0 = wr_hi; rd0 = rd_hi; dr0 = drv_cyc;
    bus.status_i = st;
    accepted = (pre >= 32) && (phy == 5'd1) && (op == 2'b10 || op == 2'b01);
    exp = model_read(ra, st);
    send_frame(pre, op, phy, ra, wd, op != 2'b01, 18, rsp);
    if (accepted && op == 2'b10) begin
      check_eq({tag, ".rdata"}, 32'(rsp), {15'd0, 1'b0, exp});
      check_eq({tag, ".rd_pulses"}, 32'(rd_hi - rd0), 32'd1);
      check_eq({tag, ".wr_pulses"}, 32'(wr_hi - wr0), 32'd0);
      check_eq({tag, ".released"}, 32'(bus.mdio_oen_o), 32'd1);
    end else if (accepted) begin
      wrable = !(ra >= 5'd1 && ra <= 5'd3);
      check_eq({tag, ".wr_pulses"}, 32'(wr_hi - wr0), 32'(wrable));
      check_eq({tag, ".rd_pulses"}, 32'(rd_hi - rd0), 32'd0);
      check_eq({tag, ".no_drive"}, 32'(drv_cyc - dr0), 32'd0);
      if (wrable) begin
        check_eq({tag, ".wr_addr"}, 32'(last_wr_addr), 32'(ra));
        check_eq({tag, ".wr_data"}, 32'(last_wr_data), 32'(wd));
      end
      model_write(ra, wd);
    end else begin
      check_eq({tag, ".ign_wr"}, 32'(wr_hi - wr0), 32'd0);
      check_eq({tag, ".ign_rd"}, 32'(rd_hi - rd0), 32'd0);
      check_eq({tag, ".ign_drive"}, 32'(drv_cyc - dr0), 32'd0);
    end
  endtask

  initial begin
    logic [16:0] rsp;
    logic [1:0]  op;
    logic [4:0]  phy, ra;
    int rd0, pick;
    bus.mdc_i = 1'b0;
    bus.status_i = 16'h0000;
    model_reset();
    repeat (4) @(posedge clk_i);
    #1;
    check_eq("rst.oen", 32'(bus.mdio_oen_o), 32'd1);
    check_eq("rst.mdio_o", 32'(bus.mdio_o), 32'd0);
    check_eq("rst.wr_valid", 32'(bus.wr_valid_o), 32'd0);
    check_eq("rst.rd_valid", 32'(bus.rd_valid_o), 32'd0);
    check_eq("rst.wr_addr", 32'(bus.wr_addr_o), 32'd0);
    check_eq("rst.wr_data", 32'(bus.wr_data_o), 32'd0);
    rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;

    do_txn(32, 2'b01, 5'd1, 5'd5, 16'hBEEF, 16'h0, "wr5");
    do_txn(32, 2'b10, 5'd1, 5'd5, 16'h0, 16'h0, "rd5");
    do_txn(32, 2'b10, 5'd1, 5'd1, 16'h0, 16'h796D, "rd1");
    do_txn(32, 2'b10, 5'd1, 5'd2, 16'h0, 16'h0, "rd2");
    do_txn(32, 2'b01, 5'd1, 5'd3, 16'h1111, 16'h0, "wr3_ro");
    do_txn(32, 2'b01, 5'd2, 5'd5, 16'h1234, 16'h0, "wr_phy2");
    do_txn(32, 2'b10, 5'd2, 5'd5, 16'h0, 16'h0, "rd_phy2");
    do_txn(32, 2'b11, 5'd1, 5'd5, 16'h4321, 16'h0, "op11");
    do_txn(32, 2'b10, 5'd1, 5'd5, 16'h0, 16'h0, "rd5_again");
    do_txn(31, 2'b01, 5'd1, 5'd6, 16'h5555, 16'h0, "pre31");
    do_txn(32, 2'b10, 5'd1, 5'd6, 16'h0, 16'h0, "rd6_after31");
    do_txn(40, 2'b01, 5'd1, 5'd6, 16'hA5A5, 16'h0, "pre40");
    do_txn(32, 2'b10, 5'd1, 5'd6, 16'h0, 16'h0, "rd6_after40");
    do_txn(32, 2'b01, 5'd1, 5'd7, 16'h1234, 16'h0, "wr7");
    do_txn(32, 2'b01, 5'd1, 5'd0, 16'h8000, 16'h0, "softrst");
    do_txn(32, 2'b10, 5'd1, 5'd7, 16'h0, 16'h0, "rd7_cleared");
    do_txn(32, 2'b10, 5'd1, 5'd0, 16'h0, 16'h0, "rd0_cleared");
    do_txn(32, 2'b01, 5'd1, 5'd5, 16'hBEEF, 16'h0, "wr5b");

    // MDC stalls mid-read; the bus must stay driven until the idle limit, then release.
    rd0 = rd_hi;
    send_frame(32, 2'b10, 5'd1, 5'd5, 16'h0, 1'b1, 6, rsp);
    check_eq("to.driving", 32'(bus.mdio_oen_o), 32'd0);
    repeat (900) @(posedge clk_i);
    #1;
    check_eq("to.before_limit", 32'(bus.mdio_oen_o), 32'd0);
    repeat (200) @(posedge clk_i);
    #1;
    check_eq("to.released", 32'(bus.mdio_oen_o), 32'd1);
    check_eq("to.rd_pulse", 32'(rd_hi - rd0), 32'd1);
    do_txn(32, 2'b10, 5'd1, 5'd5, 16'h0, 16'h0, "rd_after_to");

    for (int n = 0; n < 30; n++) begin
      pick = int'($urandom_range(0, 9));
      op   = (pick < 4) ? 2'b01 : (pick < 8) ? 2'b10 : 2'($urandom);
      phy  = (pick == 9) ? 5'($urandom) : 5'd1;
      ra   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      do_txn(int'($urandom_range(32, 40)), op, phy, ra, 16'($urandom), 16'($urandom),
             $sformatf("rnd%0d", n));
    end

    // Asynchronous reset mid-DATA releases the bus without waiting for a clock.
    send_frame(32, 2'b10, 5'd1, 5'd0, 16'h0, 1'b1, 8, rsp);
    check_eq("rstmid.driving", 32'(bus.mdio_oen_o), 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("rstmid.released", 32'(bus.mdio_oen_o), 32'd1);
    check_eq("rstmid.mdio_o", 32'(bus.mdio_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    do_txn(32, 2'b10, 5'd1, 5'd0, 16'h0, 16'h0, "rd0_after_rst");
    do_txn(32, 2'b10, 5'd1, 5'd5, 16'h0, 16'h0, "rd5_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdio_responder.md
# mdio_responder

Clause-22 MDIO management responder (PHY-side target) on the system clock. It oversamples the MDC/MDIO pins of the MAC's management master, decodes read/write frames addressed to its PHY address, and answers from a 32×16 register file. It serves as a PHY-register model for bring-up and loopback of the MAC's MDIO port, and as a management slave for on-chip logic exposed on the same bus.

## Interface
- PhyAddr, 5'd1, PHY address this block responds to; no broadcast.
- SyncDepth, 2, synchronizer flops on mdc_i and mdio_i, minimum 2.
- PreambleLen, 32, consecutive 1 bits required before a start-of-frame is accepted.
- IdleTimeout, 1024, clk_i cycles without an MDC rising edge that abort a frame.
- Reg0Reset, 16'h1140, reset value of register 0.
- PhyId1 / PhyId2, 16'h0141 / 16'h0CC2, read-only values of registers 2 and 3.
- clk_i  in  1  system clock; MDC period ≥ 8 clk_i periods.
- rst_ni  in  1  asynchronous, active-low reset.
- mdc_i  in  1  management clock from the master; asynchronous to clk_i.
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO drive value.
- mdio_oen_o  out  1  output enable, active-low: 1 = released (Z), 0 = drive mdio_o.
- status_i  in  16  live value returned for register 1.
- wr_valid_o  out  1  one-cycle pulse on each accepted write to a writable register.
- wr_addr_o  out  5  register address of that write.
- wr_data_o  out  16  data of that write.
- rd_valid_o  out  1  one-cycle pulse when a read to PhyAddr is accepted, at TA entry.

## Operation
- mdc_i and mdio_i each pass through SyncDepth flops. rise = mdc_sync & ~mdc_prev. All bit sampling and all output changes happen only in rise cycles.
- FSM states: PREAMBLE, START, OP, PHYAD, REGAD, TA, DATA, SKIP. A 5-bit bit counter and a preamble counter saturating at PreambleLen support the FSM.
- PREAMBLE: a sampled 1 increments the preamble counter. A sampled 0 with count ≥ PreambleLen goes to START; a sampled 0 with a lower count clears the counter.
- START: sampled 1 → OP. Sampled 0 → PREAMBLE with the counter cleared.
- OP: 2 bits, MSB first. 10 = read, 01 = write, 00/11 = invalid.
- PHYAD: 5 bits, then REGAD: 5 bits, both MSB first.
- On the last REGAD bit:
  - valid op and address match → TA;
  - otherwise → SKIP, which consumes 18 bits (2 TA + 16 data) without driving, then → PREAMBLE.
- Read, TA entry:
  - shift register loads the read value (reg1 = status_i captured in that cycle; reg2/3 = PhyId1/2; others from storage);
  - rd_valid_o pulses.
- Read driving sequence, one step per rise:
  - first TA rise: mdio_oen_o=0, mdio_o=0;
  - next 16 rises: mdio_o = data[15] … data[0];
  - the rise after data[0]: mdio_oen_o=1 → PREAMBLE.
- Write: TA bit values are ignored. 16 data bits are sampled MSB first. In the cycle that samples data[0], the register is updated and the FSM → PREAMBLE.
- Write results:
  - regs 1, 2, 3: write discarded, no wr_valid_o pulse.
  - all others: storage updated; wr_valid_o/addr/data presented for exactly one clk_i cycle.
- Reg0 bit 15 write = soft reset: all storage returns to reset values (reg0 = Reg0Reset with bit 15 cleared, regs 4–31 = 0). wr_valid_o still pulses with the written data. A subsequent read of reg0 returns Reg0Reset & 16'h7FFF.
- Timeout: an idle counter resets on every rise. When it reaches IdleTimeout in any state other than PREAMBLE, the FSM → PREAMBLE, the preamble counter clears, and mdio_oen_o=1.

## Timing
- Reset values:
  - mdio_oen_o=1, mdio_o=0;
  - wr_valid_o=0, rd_valid_o=0, wr_addr_o=0, wr_data_o=0;
  - FSM = PREAMBLE, counters = 0;
  - reg0 = Reg0Reset, regs 4–31 = 0.
- Latency from a physical MDC rising edge to sampling or output change: SyncDepth+1 clk_i cycles. The master samples on the following MDC rising edge, so valid read data must be driven ≥ 1 MDC period ahead.
- Reset mid-frame: the bus is released in the same cycle (asynchronous), and the frame is lost.
- A frame arriving while writes from a previous frame are presented causes no conflict: wr_* pulses last exactly one cycle.
- The preamble counter saturates and does not wrap. A preamble longer than PreambleLen is accepted.
- Back-to-back frames must each carry a full preamble.

## Test plan
- Write reg 5 = 16'hBEEF to PhyAddr=1 → one wr_valid_o pulse with addr 5, data BEEF. A subsequent read drives TA 0 then BEEF MSB first, then releases.
- Read reg 1 with status_i=16'h796D → 796D on the bus; rd_valid_o pulses once.
- Frame to PhyAddr 2, or opcode 11 → mdio_oen_o stays 1 for the whole frame; no pulses; the next valid frame is answered.
- 31-bit preamble then start → ignored. A 40-bit preamble → accepted.
- Write reg0 = 16'h8000 after reg 7 = 16'h1234 → reg7 reads 0, reg0 reads 16'h1140.
- MDC stopped after REGAD of a read for IdleTimeout cycles → bus released. A following full frame is answered. Asserting rst_ni low mid-DATA → mdio_oen_o=1 immediately.
